// File: rtl/board_mem_arbiter_if.sv
// Game-logic access port of the board RAM arbiter.
// The requester holds g_req until it sees a one-cycle g_ack.
interface board_mem_arbiter_if;
    logic       g_req;
    logic       g_we;
    logic [7:0] g_addr;
    logic [2:0] g_wdata;
    logic       g_ack;
    logic [2:0] g_rdata;

    modport master (
        output g_req, g_we, g_addr, g_wdata,
        input  g_ack, g_rdata
    );

    modport slave (
        input  g_req, g_we, g_addr, g_wdata,
        output g_ack, g_rdata
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Shares one board RAM between game logic and a per-row line-buffer prefetch for VGA.
// Optional grid overlay is enabled with macro BOARD_GRID_EN.
module board_mem_arbiter #(
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int FETCH_X  = 640
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    output logic [7:0]            mem_addr,
    output logic                  mem_we,
    output logic [2:0]            mem_wdata,
    input  logic [2:0]            mem_rdata,
    board_mem_arbiter_if.slave    gp,
    output logic [2:0]            cell_color,
    output logic                  in_board,
    output logic                  grid_px
);

    localparam logic [9:0] X0 = 10'(BOARD_X0);
    localparam logic [9:0] X1 = 10'(BOARD_X0 + 160);
    localparam logic [9:0] Y0 = 10'(BOARD_Y0);
    localparam logic [9:0] Y1 = 10'(BOARD_Y0 + 320);
    localparam logic [9:0] FX = 10'(FETCH_X);

    typedef enum logic [1:0] {IDLE, GAME, FILL} state_t;

    state_t     r_state, w_nextState;
    logic       r_fillPending;
    logic [9:0] r_lastFillY;
    logic [4:0] r_pendRow, r_row;
    logic [3:0] r_col;
    logic       r_gBad;
    logic [2:0] r_lineBuf [0:9];

    logic [9:0] w_ny, w_nyOff, w_dx;
    logic       w_rowStart, w_trigger, w_startFill, w_inBoard, w_gBad, w_gIssue;
    logic [4:0] w_trigRow;
    logic [3:0] w_bufIdx;
    logic [7:0] w_fillAddr;
    logic [2:0] w_cellNext;

    // A fill fetches the row that the *next* scan line starts, during hblank of this one.
    assign w_ny        = y + 10'd1;
    assign w_nyOff     = w_ny - Y0;
    assign w_rowStart  = (w_ny >= Y0) && (w_ny < Y1) && (w_nyOff[3:0] == 4'd0);
    assign w_trigger   = (x == FX) && w_rowStart && (r_lastFillY != y);
    assign w_trigRow   = 5'(w_nyOff >> 4);
    assign w_startFill = r_fillPending || w_trigger;

    assign w_dx       = x - X0;
    assign w_bufIdx   = 4'(w_dx >> 4);
    assign w_inBoard  = (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
    assign w_gBad     = gp.g_addr >= 8'd200;
    assign w_fillAddr = 8'(r_row) * 8'd10 + 8'(r_col);

`ifdef BOARD_GRID_EN
    logic [9:0] w_dy;
    logic       w_gridHit;
    logic       r_gridPx;

    assign w_dy      = y - Y0;
    assign w_gridHit = w_inBoard && ((w_dx[3:0] == 4'd0) || (w_dy[3:0] == 4'd0));
    assign grid_px   = r_gridPx;

    always_ff @(posedge clk) begin
        if (reset) r_gridPx <= 1'b0;
        else       r_gridPx <= w_gridHit;
    end
`else
    assign grid_px = 1'b0;
`endif

    always_comb begin
        w_cellNext = w_inBoard ? r_lineBuf[w_bufIdx] : 3'd0;
`ifdef BOARD_GRID_EN
        if (w_gridHit) w_cellNext = 3'd7;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Memory and game-port outputs are held quiet while reset is asserted.
    always_comb begin
        w_nextState = r_state;
        mem_addr    = 8'd0;
        mem_we      = 1'b0;
        mem_wdata   = 3'd0;
        gp.g_ack    = 1'b0;
        gp.g_rdata  = 3'd0;
        w_gIssue    = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_startFill) begin
                        w_nextState = FILL;
                    end else if (gp.g_req) begin
                        mem_addr    = gp.g_addr;
                        mem_we      = gp.g_we && !w_gBad;
                        mem_wdata   = gp.g_wdata;
                        w_gIssue    = 1'b1;
                        w_nextState = GAME;
                    end
                end
                GAME: begin
                    gp.g_ack    = 1'b1;
                    gp.g_rdata  = r_gBad ? 3'd0 : mem_rdata;
                    w_nextState = IDLE;
                end
                FILL: begin
                    if (r_col < 4'd10) mem_addr = w_fillAddr;
                    if (r_col == 4'd10) w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // A trigger that coincides with starting an older pending fill stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fillPending <= 1'b0;
            r_lastFillY   <= 10'h3FF;
            r_pendRow     <= 5'd0;
            r_row         <= 5'd0;
            r_col         <= 4'd0;
            r_gBad        <= 1'b0;
            cell_color    <= 3'd0;
            in_board      <= 1'b0;
            for (int i = 0; i < 10; i++) r_lineBuf[i] <= 3'd0;
        end else begin
            if (w_trigger) begin
                r_lastFillY <= y;
                r_pendRow   <= w_trigRow;
            end
            if (r_state == IDLE && w_startFill) begin
                r_fillPending <= r_fillPending && w_trigger;
                r_row         <= r_fillPending ? r_pendRow : w_trigRow;
                r_col         <= 4'd0;
            end else if (w_trigger) begin
                r_fillPending <= 1'b1;
            end
            if (r_state == FILL) begin
                r_col <= r_col + 4'd1;
                if (r_col != 4'd0) r_lineBuf[r_col - 4'd1] <= mem_rdata;
            end
            if (w_gIssue) r_gBad <= w_gBad;
            in_board   <= w_inBoard;
            cell_color <= w_cellNext;
        end
    end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 SHALL have parameter BOARD_X0, default 240: left pixel column of the 10x20 playfield.
REQ-002 SHALL have parameter BOARD_Y0, default 80: top pixel row of the playfield.
REQ-003 SHALL have parameter FETCH_X, default 640: horizontal position (in hblank) at which a row prefetch is triggered.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports x, y, input, 10 each: current pixel coordinates from the VGA timing driver.
REQ-007 SHALL have ports mem_addr (output, 8), mem_we (output, 1), mem_wdata (output, 3) and mem_rdata (input, 3): a single-port board RAM with cell address row*10+col and 1-cycle read latency.
REQ-008 SHALL have ports g_req (in, 1), g_we (in, 1), g_addr (in, 8), g_wdata (in, 3), g_ack (out, 1) and g_rdata (out, 3): the game-logic access port.
REQ-009 SHALL have ports cell_color (output, 3) and in_board (output, 1): registered colour index and playfield flag for the current pixel.
REQ-010 SHALL have port grid_px, output, 1: grid-line flag (see Configuration).

Function
REQ-011 SHALL implement the states IDLE, GAME and FILL.
REQ-012 SHALL define the row start condition: ny=y+1 lies in [BOARD_Y0, BOARD_Y0+320) and (ny-BOARD_Y0)[3:0]==0.
REQ-013 SHALL set fill_pending when x==FETCH_X, the row start condition holds and last_fill_y!=y; SHALL record last_fill_y=y at that point, so there is exactly one fill per line even if x is held for several clocks.
REQ-014 SHALL, in IDLE, give fill_pending priority: go to FILL with fill row r=(ny-BOARD_Y0)>>4 and column 0.
REQ-015 SHALL, in IDLE with no pending fill and g_req=1, drive mem_addr=g_addr, mem_we=g_we and mem_wdata=g_wdata for one cycle, then go to GAME.
REQ-016 SHALL, in GAME, pulse g_ack high for exactly one cycle with g_rdata=mem_rdata (write accesses return don't-care data), then return to IDLE; each game access therefore costs 2 cycles.
REQ-017 SHALL, in FILL, issue reads at r*10+col for col 0..9 on consecutive cycles with mem_we=0, and write each returned word into line_buf[col-1] one cycle later; after col 9 the last data is captured and the state returns to IDLE. FILL lasts 11 cycles and clears fill_pending.
REQ-018 SHALL hold off g_req while in FILL without dropping it; the requester keeps g_req high until g_ack.
REQ-019 SHALL, when a fill triggers while in GAME, let the game access complete first, with FILL starting at most 2 cycles after the trigger.
REQ-020 SHALL drive mem_we=0 and mem_addr=0 in IDLE when no access is issued.
REQ-021 SHALL register in_board one cycle after x,y, asserted when x is in [BOARD_X0, BOARD_X0+160) and y is in [BOARD_Y0, BOARD_Y0+320).
REQ-022 SHALL register cell_color=line_buf[(x-BOARD_X0)>>4] when in board, else 0.
REQ-023 SHALL treat g_addr>=200 as an access with no effect: no write, g_rdata=0, and g_ack still pulsed.

Reset
REQ-024 SHALL, on synchronous reset, set state=IDLE, fill_pending=0, last_fill_y=10'h3FF, all 10 line_buf entries=0, and g_ack=0, g_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, cell_color=0, in_board=0 and grid_px=0.
REQ-025 SHALL, on reset mid-FILL or mid-GAME, abort the operation; no g_ack is issued for the aborted access.

Configuration
REQ-026 SHALL, with macro BOARD_GRID_EN defined, register grid_px=1 for in-board pixels where (x-BOARD_X0)[3:0]==0 or (y-BOARD_Y0)[3:0]==0, and force cell_color=3'd7 on those pixels.
REQ-027 SHALL, without BOARD_GRID_EN, tie grid_px to 0 and leave cell_color unmodified.

Verification
REQ-028 SHALL pass: after reset, g_req with g_we=1, g_addr=25, g_wdata=5 -> mem_we=1 and mem_addr=25 for 1 cycle, and g_ack pulses the next cycle.
REQ-029 SHALL pass: RAM row 0 preloaded with 1..7,1,2,3, then y=79, x=640 -> reads at addresses 0..9 over 10 cycles, and at y=80, x=240..255 cell_color=1 while x=384 gives 3.
REQ-030 SHALL pass: g_req held during FILL -> no g_ack until FILL ends, then exactly one g_ack.
REQ-031 SHALL pass: x held at 640 for 4 clocks on y=95 -> exactly one fill of row 1 (addresses 10..19).
REQ-032 SHALL pass: reset asserted on the 5th FILL cycle -> state IDLE, line_buf all 0, and no further reads.
REQ-033 SHALL pass with BOARD_GRID_EN: pixel (240,90) -> grid_px=1 and cell_color=7; pixel (241,90) -> grid_px=0.
